lcd_byte_writer: RTL and testbench

Byte-level HD44780 bus driver sitting directly downstream of the character-LCD sequencer. It accepts one command or data byte per start/done handshake and drives the pmod-charlcd 8-bit parallel bus (D7..D0, RS, E) with controller-compliant setup, enable-pulse, hold and execution timing. It enforces the power-on delay before the first transfer. It returns a single-cycle `done_tick` once the controller is ready for the next byte.

---
 rtl/lcd_byte_writer_if.sv | 34 +++
 rtl/lcd_byte_writer.sv | 161 ++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_byte_writer_if.sv
// Byte handshake and HD44780 parallel-bus signals for lcd_byte_writer.
// The master is the upstream sequencer and the slave is the bus driver.
interface lcd_byte_writer_if;
    logic [7:0] data;
    logic       start;
    logic       cd;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_en;
    logic       done_tick;
    logic       busy;

    modport master (
        output data,
        output start,
        output cd,
        input  lcd_d,
        input  lcd_rs,
        input  lcd_en,
        input  done_tick,
        input  busy
    );

    modport slave (
        input  data,
        input  start,
        input  cd,
        output lcd_d,
        output lcd_rs,
        output lcd_en,
        output done_tick,
        output busy
    );
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 8-bit bus driver: one command/data byte per start/done handshake,
// with power-on delay, setup/enable/hold timing and execution wait.
module lcd_byte_writer #(
    parameter int unsigned POWERUP_CYC = 600000,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned EN_CYC      = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned EXEC_CYC    = 600,
    parameter int unsigned LONG_CYC    = 24000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_byte_writer_if.slave  bus
);

    // Every timed state lasts at least one cycle.
    localparam int unsigned PWR_T   = (POWERUP_CYC < 1) ? 1 : POWERUP_CYC;
    localparam int unsigned SETUP_T = (SETUP_CYC   < 1) ? 1 : SETUP_CYC;
    localparam int unsigned EN_T    = (EN_CYC      < 1) ? 1 : EN_CYC;
    localparam int unsigned HOLD_T  = (HOLD_CYC    < 1) ? 1 : HOLD_CYC;
    localparam int unsigned EXEC_T  = (EXEC_CYC    < 1) ? 1 : EXEC_CYC;
    localparam int unsigned LONG_T  = (LONG_CYC    < 1) ? 1 : LONG_CYC;

    localparam logic [19:0] PWR_LAST   = 20'(PWR_T - 1);
    // The accept cycle presents the bus; SETUP_T further cycles follow before E rises.
    localparam logic [19:0] SETUP_LAST = 20'(SETUP_T);
    localparam logic [19:0] EN_LAST    = 20'(EN_T - 1);
    localparam logic [19:0] HOLD_LAST  = 20'(HOLD_T - 1);
    localparam logic [19:0] EXEC_LAST  = 20'(EXEC_T - 1);
    localparam logic [19:0] LONG_LAST  = 20'(LONG_T - 1);

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_EXEC    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t      state_q;
    logic [19:0] cnt_q;
    logic        long_q;
    logic [7:0]  lcd_d_q;
    logic        lcd_rs_q;
    logic        lcd_en_q;
    logic        done_q;
    logic        busy_q;

    logic [19:0] cnt_d;
    logic [19:0] term_cnt;
    logic        at_term;
    logic        long_cmd;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign long_cmd = ~bus.cd && (bus.data[7:2] == 6'd0) && (bus.data[1:0] != 2'd0);

    always_comb begin
        cnt_d = cnt_q + 20'd1;
        case (state_q)
            ST_POWERUP: term_cnt = PWR_LAST;
            ST_SETUP:   term_cnt = SETUP_LAST;
            ST_PULSE:   term_cnt = EN_LAST;
            ST_HOLD:    term_cnt = HOLD_LAST;
            ST_EXEC:    term_cnt = long_q ? LONG_LAST : EXEC_LAST;
            default:    term_cnt = 20'd0;
        endcase
    end

    assign at_term = (cnt_q == term_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_POWERUP;
            cnt_q    <= 20'd0;
            long_q   <= 1'b0;
            lcd_d_q  <= 8'h00;
            lcd_rs_q <= 1'b0;
            lcd_en_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_POWERUP: begin
                    if (at_term) begin
                        cnt_q   <= 20'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_IDLE: begin
                    cnt_q <= 20'd0;
                    if (bus.start) begin
                        lcd_d_q  <= bus.data;
                        lcd_rs_q <= bus.cd;
                        long_q   <= long_cmd;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (at_term) begin
                        cnt_q    <= 20'd0;
                        lcd_en_q <= 1'b1;
                        state_q  <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_PULSE: begin
                    if (at_term) begin
                        cnt_q    <= 20'd0;
                        lcd_en_q <= 1'b0;
                        state_q  <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HOLD: begin
                    if (at_term) begin
                        cnt_q   <= 20'd0;
                        state_q <= ST_EXEC;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_EXEC: begin
                    if (at_term) begin
                        cnt_q   <= 20'd0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= 20'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q    <= 20'd0;
                    lcd_en_q <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= ST_POWERUP;
                end
            endcase
        end
    end

    assign bus.lcd_d     = lcd_d_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_en    = lcd_en_q;
    assign bus.done_tick = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: directed and random byte transfers
// compared against a timing model built from the transfer rules.
module tb_lcd_byte_writer;

    localparam int POWERUP_CYC = 20;
    localparam int SETUP_CYC   = 1;
    localparam int EN_CYC      = 4;
    localparam int HOLD_CYC    = 1;
    localparam int EXEC_CYC    = 10;
    localparam int LONG_CYC    = 50;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    lcd_byte_writer_if bus_if ();

    lcd_byte_writer #(
        .POWERUP_CYC (POWERUP_CYC),
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .EXEC_CYC    (EXEC_CYC),
        .LONG_CYC    (LONG_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every E pulse seen on the bus, as {rs, d} captured when E goes high.
    logic [8:0] pulses[$];
    logic       en_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_if.lcd_en === 1'b1 && en_prev !== 1'b1)
            pulses.push_back({bus_if.lcd_rs, bus_if.lcd_d});
        en_prev = bus_if.lcd_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long(input logic [7:0] d, input logic c);
        return !c && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    // Edges from acceptance to the start of the done_tick cycle.
    function automatic int xfer_len(input logic [7:0] d, input logic c);
        return 1 + SETUP_CYC + EN_CYC + HOLD_CYC + (is_long(d, c) ? LONG_CYC : EXEC_CYC);
    endfunction

    // Called just after acceptance edge k. mode 0: drop start; mode 1: hold start
    // and present the next byte in DONE; mode 2: drop start one cycle after done_tick.
    task automatic check_xfer(input logic [7:0] d, input logic c, input int mode,
                              input logic [7:0] nd, input logic nc, input bit toggle);
        int t_done, rise_n, hi_cnt, en_bad, done_n, done_cnt, bad_bus, bad_busy;
        t_done = xfer_len(d, c);
        rise_n = -1; hi_cnt = 0; en_bad = 0; done_n = -1; done_cnt = 0;
        bad_bus = 0; bad_busy = 0;
        for (int n = 0; n <= t_done + 1; n++) begin
            @(negedge clk);
            if (mode == 0 && (n == 0 || n >= t_done)) bus_if.start = 1'b0;
            if (toggle && n > 1 + SETUP_CYC + EN_CYC + HOLD_CYC && n < t_done) begin
                bus_if.data  = 8'($urandom);
                bus_if.cd    = 1'($urandom);
                bus_if.start = 1'($urandom);
            end
            if (mode == 1 && n == t_done) begin
                bus_if.data = nd; bus_if.cd = nc;
            end
            if (mode == 2 && n == t_done) begin
                bus_if.start = 1'b0; bus_if.data = nd; bus_if.cd = nc;
            end
            if (mode == 2 && n == t_done + 1) bus_if.start = 1'b1;
            if (n >= 1 && (bus_if.lcd_d !== d || bus_if.lcd_rs !== c)) bad_bus++;
            if (bus_if.lcd_en === 1'b1) begin
                if (rise_n < 0) rise_n = n;
                hi_cnt++;
            end
            if (bus_if.lcd_en !== ((n >= 1 + SETUP_CYC) && (n < 1 + SETUP_CYC + EN_CYC))) en_bad++;
            if (bus_if.done_tick === 1'b1) begin
                if (done_n < 0) done_n = n;
                done_cnt++;
            end
            if (bus_if.busy !== (n <= t_done)) bad_busy++;
        end
        chk("en_rise", rise_n, 1 + SETUP_CYC);
        chk("en_width", hi_cnt, EN_CYC);
        chk("en_window", en_bad, 0);
        chk("done_at", done_n, t_done);
        chk("done_once", done_cnt, 1);
        chk("bus_stable", bad_bus, 0);
        chk("busy", bad_busy, 0);
        $display("xfer d=%02h rs=%0d long=%0d en_rise=%0d done_at=%0d (exp %0d)",
                 d, c, is_long(d, c), rise_n, done_n, t_done);
    endtask

    // Called at a negedge; waits for IDLE, then requests a transfer at the next edge.
    task automatic start_xfer(input logic [7:0] d, input logic c);
        int w;
        w = 0;
        while (bus_if.busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", (w < 200), 1);
        bus_if.data = d; bus_if.cd = c; bus_if.start = 1'b1;
        @(posedge clk);
    endtask

    // Releases reset with start held high; the first byte must wait out power-up.
    task automatic powerup_check(input logic [7:0] d, input logic c);
        int bad;
        bad = 0;
        bus_if.data = d; bus_if.cd = c; bus_if.start = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= POWERUP_CYC; n++) begin
            @(negedge clk);
            if (bus_if.lcd_en !== 1'b0 || bus_if.done_tick !== 1'b0 || bus_if.lcd_d !== 8'h00) bad++;
            if (bus_if.busy !== (n < POWERUP_CYC)) bad++;
        end
        chk("powerup_quiet", bad, 0);
        $display("powerup %0d cycles, violations=%0d", POWERUP_CYC, bad);
        @(posedge clk);
        check_xfer(d, c, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},   bus_if.lcd_en, 0);
        chk({tag, "_rs"},   bus_if.lcd_rs, 0);
        chk({tag, "_d"},    bus_if.lcd_d, 0);
        chk({tag, "_done"}, bus_if.done_tick, 0);
        chk({tag, "_busy"}, bus_if.busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, d2;
        logic       c, c2;
        logic [7:0] dir_d[7];
        logic       dir_c[7];
        checks = 0; failures = 0;

        // Reset with a pending request that power-up must ignore.
        rst = 1'b0;
        bus_if.data = 8'h38; bus_if.cd = 1'b0; bus_if.start = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        powerup_check(8'h38, 1'b0);

        // Data write with data/cd/start toggled while executing.
        start_xfer(8'h41, 1'b1);
        check_xfer(8'h41, 1'b1, 0, 8'h00, 1'b0, 1'b1);

        // Long and short command boundaries.
        dir_d = '{8'h01, 8'h0E, 8'h00, 8'h02, 8'h03, 8'h04, 8'h02};
        dir_c = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 7; i++) begin
            start_xfer(dir_d[i], dir_c[i]);
            check_xfer(dir_d[i], dir_c[i], 0, 8'h00, 1'b0, 1'b0);
        end

        // Sequencer handshake: "HI" then 0xC0, start low one cycle after each done.
        pulses.delete();
        start_xfer(8'h48, 1'b1);
        check_xfer(8'h48, 1'b1, 2, 8'h49, 1'b1, 1'b0);
        @(posedge clk);
        check_xfer(8'h49, 1'b1, 2, 8'hC0, 1'b0, 1'b0);
        @(posedge clk);
        check_xfer(8'hC0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("hs_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("hs_pulse0", pulses[0], {1'b1, 8'h48});
            chk("hs_pulse1", pulses[1], {1'b1, 8'h49});
            chk("hs_pulse2", pulses[2], {1'b0, 8'hC0});
        end
        $display("handshake pulses=%0d", pulses.size());

        // Back-to-back: start held through DONE, next byte one IDLE cycle later.
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); c = 1'($urandom);
            d2 = 8'($urandom_range(0, 3)); c2 = 1'($urandom);
            start_xfer(d, c);
            check_xfer(d, c, 1, d2, c2, 1'b0);
            @(posedge clk);
            check_xfer(d2, c2, 0, 8'h00, 1'b0, 1'b0);
        end

        // Random transfers, biased toward the clear/home boundary.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 4));
            else d = 8'($urandom);
            c = 1'($urandom);
            start_xfer(d, c);
            check_xfer(d, c, 0, 8'h00, 1'b0, 1'b1);
        end

        // Reset during the second E-high cycle.
        start_xfer(8'h55, 1'b1);
        @(negedge clk); bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_en", bus_if.lcd_en, 1);
        pulses.delete();
        rst = 1'b0;
        #1;
        chk_reset_outputs("midpulse");
        repeat (3) @(negedge clk);
        powerup_check(8'hA5, 1'b1);
        chk("post_reset_pulses", pulses.size(), 1);
        if (pulses.size() == 1) chk("post_reset_byte", pulses[0], {1'b1, 8'hA5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
